txn_launcher: RTL and testbench
===============================

// Module: txn_launcher
// PURPOSE
//  Parametrised multi-channel transaction launcher in front of the bus masters.
//  Synchronises and debounces NUM_CH raw trigger inputs and queues one request per debounced rising edge.
//  Issues queued requests one at a time as start/mode/channel to the bus master and waits for ready or timeout.
//  Generalises the single button/start/mode/ready control path to N channels with queueing and a watchdog.
// PARAMETERS
//  NUM_CH           2     number of trigger channels (>=1)
//  MODE_W           1     mode field width per channel (0=read, 1=write when MODE_W=1)
//  FIFO_DEPTH       4     request queue depth (power of 2, >=2)
//  DEBOUNCE_CYCLES  16    consecutive stable cycles needed to accept a level change (>=1)
//  TIMEOUT_CYCLES   4096  max WAIT cycles before abort (>=2)
// PORTS
//  clk          in   1                clock, all logic rising-edge
//  rstn         in   1                reset, asynchronous, active-low
//  trig_i       in   NUM_CH           raw asynchronous trigger per channel, active-high
//  trig_mode_i  in   NUM_CH*MODE_W    per-channel mode; sampled when that channel's edge is queued
//  start_o      out  1                one-cycle launch pulse to bus master
//  mode_o       out  MODE_W           mode of the active request; held from LAUNCH through WAIT
//  ch_o         out  $clog2(NUM_CH)   channel of the active request (width 1 when NUM_CH=1)
//  ready_i      in   1                completion from bus master; single-cycle pulse or level
//  busy_o       out  1                high in LAUNCH, WAIT and GAP
//  timeout_o    out  1                one-cycle pulse on watchdog abort
//  drop_o       out  1                one-cycle pulse when an edge is lost
//  pending_o    out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; pending flags 0; debounced states 0; FSM IDLE.
//  Input path, per channel:
//   - 2-FF synchroniser feeds the debouncer.
//   - When the sync level differs from the debounced state for DEBOUNCE_CYCLES consecutive cycles, the debounced state takes the new value.
//   - Any cycle in which the levels are equal clears the debounce counter.
//   - A debounced 0->1 sets that channel's sticky pending flag and latches its trig_mode_i slice on the next cycle.
//   - A new edge on a channel whose pending flag is still set pulses drop_o. The flag and latched mode are unchanged.
//  Arbiter:
//   - At most one FIFO push per cycle, round-robin over set pending flags.
//   - The pointer starts at channel 0 and moves to the channel after the last one granted.
//   - The granted flag clears on push. Entry = {ch, mode}.
//   - Push is allowed when FIFO is not full, or when it is full and popping in the same cycle.
//   - Otherwise flags wait. Flags are never lost while the FIFO is full.
//  FSM (IDLE, LAUNCH, WAIT, GAP):
//   - IDLE: if the FIFO is non-empty, pop, register ch_o/mode_o, go to LAUNCH. ready_i is ignored.
//   - LAUNCH: start_o=1 for exactly this cycle; clear the watchdog; go to WAIT.
//   - WAIT: ready_i=1 -> GAP.
//   - WAIT: otherwise the watchdog increments. When it reaches TIMEOUT_CYCLES-1 -> pulse timeout_o, go to GAP.
//   - WAIT: ready_i and timeout in the same cycle count as completion; timeout_o is not pulsed.
//   - GAP: one idle cycle so a level-type ready deasserts; then IDLE.
//   - ch_o/mode_o hold their value until the next pop.
//  Latency:
//   - Raw edge to FIFO push: 2 + DEBOUNCE_CYCLES + 2 cycles when uncontended.
//   - Pop to start_o: 1 cycle.
//   - Back-to-back requests: start pulses at least 4 cycles apart.
//  Reset mid-operation: everything returns to reset values immediately. No partial start_o.
//  pending_o: registered count, updated the cycle after push/pop. Push and pop in the same cycle leave it unchanged.
// CONFIGURATION
//  TXN_LAUNCHER_STATS_EN defined:
//   - Adds output done_cnt_o[15:0]: +1 per ready-completion.
//   - Adds output tmo_cnt_o[15:0]: +1 per timeout.
//   - Adds output drop_cnt_o[15:0]: +1 per drop_o.
//   - All three reset to 0 and saturate at 16'hFFFF.
//  Not defined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//  1 Reset/defaults:
//    rstn=0 for 5 cycles -> every output 0, pending_o=0.
//    Assert rstn=0 mid-WAIT -> busy_o=0 asynchronously.
//  2 Single launch, DEBOUNCE_CYCLES=4:
//    trig_i[0] high 10 cycles, mode=1 -> one start_o pulse with ch_o=0, mode_o=1.
//    ready_i after 20 cycles -> busy_o low 2 cycles later.
//  3 Bounce rejection:
//    trig_i[1] toggled every 2 cycles for 40 cycles, then held low -> no push, no start_o, drop_o=0.
//  4 Simultaneous/round-robin:
//    Ch0 and ch1 debounce on the same cycle -> ch0 pushed first, ch1 next cycle.
//    Launch order: ch0 then ch1.
//  5 Full/drop, FIFO_DEPTH=2, ready_i held 0:
//    Five edges on ch0 -> 1 active + 2 queued + 1 pending; 5th edge pulses drop_o once.
//    pending_o=2.
//  6 Timeout, TIMEOUT_CYCLES=16:
//    Ready never arrives -> timeout_o pulses 16 cycles after start_o; the next queued request launches.
//    With TXN_LAUNCHER_STATS_EN: tmo_cnt_o=1.

Source files
------------

// File: rtl/txn_launcher.sv
// rtl/txn_launcher.sv - multi-channel debounced trigger queue and start/ready launcher.
// Optional TXN_LAUNCHER_STATS_EN adds done/timeout/drop event counters.
module txn_launcher #(
  parameter  int NUM_CH          = 2,
  parameter  int MODE_W          = 1,
  parameter  int FIFO_DEPTH      = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  parameter  int TIMEOUT_CYCLES  = 4096,
  localparam int CH_W            = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        trig_i,
  input  logic [NUM_CH*MODE_W-1:0] trig_mode_i,
  output logic                     start_o,
  output logic [MODE_W-1:0]        mode_o,
  output logic [CH_W-1:0]          ch_o,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic                     timeout_o,
  output logic                     drop_o,
`ifdef TXN_LAUNCHER_STATS_EN
  output logic [15:0]              done_cnt_o,
  output logic [15:0]              tmo_cnt_o,
  output logic [15:0]              drop_cnt_o,
`endif
  output logic [CNT_W-1:0]         pending_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam int ENT_W = CH_W + MODE_W;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  logic [NUM_CH-1:0] sync1_q, sync2_q, deb_q, deb_prev_q, pend_q, pend_d;
  logic [NUM_CH-1:0] rise, drop_vec, grant_vec;
  logic [DB_W-1:0]   db_cnt_q   [NUM_CH];
  logic [MODE_W-1:0] mode_lat_q [NUM_CH];
  logic              drop_q;

  logic [CH_W-1:0]   rr_q, grant_ch, hi_ch, lo_ch;
  logic [MODE_W-1:0] grant_mode, hi_mode, lo_mode;
  logic              grant_vld, hi_vld, lo_vld;

  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              fifo_full, fifo_empty, push, pop;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CH_W-1:0]   ch_q;
  logic [MODE_W-1:0] mode_q;

  // A rise on a channel whose flag is being granted this cycle re-arms the flag instead of dropping.
  always_comb begin
    rise     = deb_q & ~deb_prev_q;
    drop_vec = rise & pend_q & ~grant_vec;
    pend_d   = (pend_q & ~grant_vec) | rise;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pend_q     <= '0;
      drop_q     <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        db_cnt_q[c]   <= '0;
        mode_lat_q[c] <= '0;
      end
    end else begin
      sync1_q    <= trig_i;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      pend_q     <= pend_d;
      drop_q     <= |drop_vec;
      for (int c = 0; c < NUM_CH; c++) begin
        if (sync2_q[c] == deb_q[c]) begin
          db_cnt_q[c] <= '0;
        end else if (db_cnt_q[c] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[c]    <= sync2_q[c];
          db_cnt_q[c] <= '0;
        end else begin
          db_cnt_q[c] <= db_cnt_q[c] + 1'b1;
        end
        if (rise[c] && !drop_vec[c]) mode_lat_q[c] <= trig_mode_i[c*MODE_W +: MODE_W];
      end
    end
  end

  // Round-robin: lowest set flag at or above the pointer, else lowest set flag overall.
  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_ch   = '0;
    lo_ch   = '0;
    hi_mode = '0;
    lo_mode = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (pend_q[c]) begin
        lo_vld  = 1'b1;
        lo_ch   = CH_W'(c);
        lo_mode = mode_lat_q[c];
        if (CH_W'(c) >= rr_q) begin
          hi_vld  = 1'b1;
          hi_ch   = CH_W'(c);
          hi_mode = mode_lat_q[c];
        end
      end
    end
    grant_vld  = lo_vld;
    grant_ch   = hi_vld ? hi_ch : lo_ch;
    grant_mode = hi_vld ? hi_mode : lo_mode;
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    pop        = (state_q == S_IDLE) && !fifo_empty;
    push       = grant_vld && (!fifo_full || pop);
    grant_vec  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (push && grant_ch == CH_W'(c)) grant_vec[c] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {grant_ch, grant_mode};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ch_q     <= '0;
      mode_q   <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        rr_q     <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
      end
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + 1'b1;
        {ch_q, mode_q} <= fifo_mem[rd_ptr_q];
      end
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Ready arriving on the final watchdog cycle wins over the timeout.
  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    start_o   = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      S_IDLE:   if (!fifo_empty) state_d = S_LAUNCH;
      S_LAUNCH: begin
        start_o = 1'b1;
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ready_i) begin
          state_d = S_GAP;
        end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_o = 1'b1;
          state_d   = S_GAP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_GAP:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign ch_o      = ch_q;
  assign mode_o    = mode_q;
  assign drop_o    = drop_q;
  assign pending_o = count_q;

`ifdef TXN_LAUNCHER_STATS_EN
  logic done_evt;
  assign done_evt = (state_q == S_WAIT) && ready_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done_cnt_o <= '0;
      tmo_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (done_evt && done_cnt_o != 16'hFFFF)  done_cnt_o <= done_cnt_o + 1'b1;
      if (timeout_o && tmo_cnt_o != 16'hFFFF)  tmo_cnt_o  <= tmo_cnt_o + 1'b1;
      if (drop_q && drop_cnt_o != 16'hFFFF)    drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_txn_launcher.sv
// tb/tb_txn_launcher.sv - randomized scoreboard bench for txn_launcher.
module tb_txn_launcher;
  localparam int DEB = 4;
  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [1:0] trig_i = '0;
  logic [1:0] trig_mode_i = '0;
  logic       ready_i = 1'b0;
  logic       start_o, busy_o, timeout_o, drop_o;
  logic [0:0] mode_o;
  logic [0:0] ch_o;
  logic [1:0] pending_o;
`ifdef TXN_LAUNCHER_STATS_EN
  logic [15:0] done_cnt_o, tmo_cnt_o, drop_cnt_o;
`endif

  txn_launcher #(
    .NUM_CH(2), .MODE_W(1), .FIFO_DEPTH(2), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .trig_i(trig_i), .trig_mode_i(trig_mode_i),
    .start_o(start_o), .mode_o(mode_o), .ch_o(ch_o), .ready_i(ready_i),
    .busy_o(busy_o), .timeout_o(timeout_o), .drop_o(drop_o),
`ifdef TXN_LAUNCHER_STATS_EN
    .done_cnt_o(done_cnt_o), .tmo_cnt_o(tmo_cnt_o), .drop_cnt_o(drop_cnt_o),
`endif
    .pending_o(pending_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int launch_q[$];
  int tmo_q[$];
  int idle_q[$];
  int drop_exp = 0, drop_seen = 0, tmo_seen = 0;
  int rr_model = 0;
  int last_start = -100;
  bit force_tmo = 1'b0;
  bit busy_prev = 1'b0;
  int mon_e;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (start_o) begin
        check("launch_expected", int'(launch_q.size() > 0), 1);
        if (launch_q.size() > 0) begin
          mon_e = launch_q.pop_front();
          check("launch_ch", int'(ch_o), mon_e / 2);
          check("launch_mode", int'(mode_o), mon_e % 2);
        end
        check("start_spacing", int'(cyc - last_start >= 4), 1);
        last_start = cyc;
      end
      if (timeout_o) begin
        tmo_seen++;
        check("timeout_expected", int'(tmo_q.size() > 0), 1);
        if (tmo_q.size() > 0) check("timeout_cycle", cyc, tmo_q.pop_front());
      end
      if (busy_prev && !busy_o) begin
        check("idle_expected", int'(idle_q.size() > 0), 1);
        if (idle_q.size() > 0) check("idle_cycle", cyc, idle_q.pop_front());
      end
      if (drop_o) drop_seen++;
    end
    busy_prev = busy_o;
  end

  int rs, rw;
  bit rlvl;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rstn && start_o) begin
        rs = cyc;
        if (force_tmo || $urandom_range(0, 3) == 0) begin
          tmo_q.push_back(rs + TMO);
          idle_q.push_back(rs + TMO + 2);
          repeat (TMO + 1) @(posedge clk);
        end else begin
          rw   = ($urandom_range(0, 4) == 0) ? TMO - 1 : int'($urandom_range(0, TMO - 1));
          rlvl = 1'($urandom_range(0, 1));
          repeat (rw + 1) @(posedge clk);
          #1 ready_i = 1'b1;
          idle_q.push_back(rs + 1 + rw + 2);
          @(posedge clk); #1;
          if (rlvl) begin
            @(posedge clk); #1;
          end
          ready_i = 1'b0;
        end
      end
    end
  end

  task automatic wait_drain();
    int k;
    for (k = 0; k < 800; k++) begin
      if (launch_q.size() == 0 && tmo_q.size() == 0 && idle_q.size() == 0 && !busy_o && pending_o == 0) break;
      @(posedge clk); #1;
    end
    check("drain_within_budget", int'(k < 800), 1);
  endtask

  int ts[2], hold[2], run[2];
  bit bnc[2];
  logic [1:0] lv, mask, modes;
  int first, second, drop_before, k;
  logic m[5];

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("rst_start", int'(start_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    check("rst_drop", int'(drop_o), 0);
    check("rst_pending", int'(pending_o), 0);
    check("rst_ch", int'(ch_o), 0);
    check("rst_mode", int'(mode_o), 0);
    rstn = 1'b1;

    for (int t = 0; t < 40; t++) begin
      trig_i[1] = 1'((t / 2) % 2);
      @(posedge clk); #1;
      check("bounce_pending", int'(pending_o), 0);
    end
    trig_i = '0;
    repeat (20) @(posedge clk);
    #1;
    check("bounce_busy", int'(busy_o), 0);
    check("bounce_drop", drop_seen, 0);

    for (int ep = 0; ep < 16; ep++) begin
      mask  = (ep == 0) ? 2'b11 : 2'($urandom_range(1, 3));
      modes = 2'($urandom_range(0, 3));
      for (int c = 0; c < 2; c++) begin
        ts[c]   = 8 + ((ep == 0) ? 0 : int'($urandom_range(0, 1)));
        hold[c] = $urandom_range(1, 6);
        bnc[c]  = 1'($urandom_range(0, 1));
        run[c]  = 0;
      end
      trig_mode_i = modes;
      if (mask == 2'b11) begin
        if (ts[0] < ts[1])      first = 0;
        else if (ts[1] < ts[0]) first = 1;
        else                    first = rr_model;
        second = 1 - first;
        launch_q.push_back(first * 2 + int'(modes[first]));
        launch_q.push_back(second * 2 + int'(modes[second]));
        rr_model = (second + 1) % 2;
      end else begin
        first = mask[0] ? 0 : 1;
        launch_q.push_back(first * 2 + int'(modes[first]));
        rr_model = (first + 1) % 2;
      end
      for (int t = 0; t < 40; t++) begin
        for (int c = 0; c < 2; c++) begin
          lv[c] = 1'b0;
          if (mask[c]) begin
            if (t >= ts[c] && t < ts[c] + DEB + hold[c]) lv[c] = 1'b1;
            else if (bnc[c] && t < ts[c] - 2 && run[c] < DEB - 1 && $urandom_range(0, 1) == 1) lv[c] = 1'b1;
          end
          run[c] = lv[c] ? run[c] + 1 : 0;
        end
        trig_i = lv;
        @(posedge clk); #1;
      end
      trig_i = '0;
      wait_drain();
    end

    force_tmo   = 1'b1;
    drop_before = drop_seen;
    for (int e = 0; e < 5; e++) begin
      m[e] = 1'($urandom_range(0, 1));
      if (e < 4) launch_q.push_back(int'(m[e]));
    end
    drop_exp++;
    rr_model = 1;
    for (int e = 0; e < 5; e++) begin
      trig_mode_i = {1'b0, m[e]};
      trig_i[0]   = 1'b1;
      repeat (5) begin
        @(posedge clk); #1;
        if (e == 4) check("full_pending", int'(pending_o), 2);
      end
      trig_i[0] = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
      end
    end
    check("full_drop_pulse", drop_seen - drop_before, 1);
    wait_drain();
`ifdef TXN_LAUNCHER_STATS_EN
    check("stats_tmo", int'(tmo_cnt_o), tmo_seen);
    check("stats_drop", int'(drop_cnt_o), drop_seen);
`endif

    trig_mode_i = 2'b01;
    launch_q.push_back(1);
    trig_i[0] = 1'b1;
    repeat (DEB + 4) begin
      @(posedge clk); #1;
    end
    trig_i[0] = 1'b0;
    for (k = 0; k < 100; k++) begin
      if (busy_o) break;
      @(posedge clk); #1;
    end
    check("mid_busy_seen", int'(k < 100), 1);
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_busy", int'(busy_o), 0);
    check("async_rst_start", int'(start_o), 0);
    check("async_rst_pending", int'(pending_o), 0);
    tmo_q.delete();
    idle_q.delete();
    check("launch_q_empty", launch_q.size(), 0);
    check("drop_total", drop_seen, drop_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
